// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage and its SRAM controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    localparam int unsigned CntW          = 4;
    localparam int unsigned DefAddrOffset = 1024;

    localparam logic HalfLo = 1'b0;
    localparam logic HalfHi = 1'b1;

endpackage

// File: rtl/mem_sram_stage_if.sv
// Bus to an external 16-bit asynchronous SRAM with active-low strobes.
interface mem_sram_stage_if #(
    parameter int unsigned SRAM_AW = 18
);
    logic [SRAM_AW-1:0] addr;
    logic [15:0]        wdata;
    logic [15:0]        rdata;
    logic               we_n;
    logic               oe_n;

    modport master (output addr, output wdata, output we_n, output oe_n, input rdata);
    modport slave  (input addr, input wdata, input we_n, input oe_n, output rdata);
endinterface

// File: rtl/sram_ctrl.sv
// Two-halfword SRAM access sequencer with programmable wait states.
// MEM_ERR_EN adds a sticky error flag that short-circuits misaligned/out-of-range accesses.
module sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_OFFSET = DefAddrOffset,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              is_store,
    input  logic [31:0]       alu_res,
    input  logic [31:0]       val_rm,
    mem_sram_stage_if.master  sram,
`ifdef MEM_ERR_EN
    output logic              mem_err,
`endif
    output logic              done,
    output logic [31:0]       rd_data
);

    localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       lo_q, lo_d, hi_q, hi_d;
    logic [SRAM_AW-1:0] lo_addr, hi_addr;
    logic              last, bad;

    assign lo_addr = SRAM_AW'({(alu_res - 32'(ADDR_OFFSET)) >> 2, HalfLo});
    assign hi_addr = SRAM_AW'({(alu_res - 32'(ADDR_OFFSET)) >> 2, HalfHi});
    assign last    = (cnt_q == WaitLast);

`ifdef MEM_ERR_EN
    logic err_q;
    assign bad     = (alu_res[1:0] != 2'b00) || (alu_res < 32'(ADDR_OFFSET));
    assign mem_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else if (state_q == StIdle && req && bad) err_q <= 1'b1;
    end
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        sram.addr  = '0;
        sram.wdata = '0;
        sram.we_n  = 1'b1;
        sram.oe_n  = 1'b1;
        case (state_q)
            StIdle: begin
                if (req && bad) begin
                    // Faulted access skips the SRAM and returns zero data.
                    state_d = StDone;
                    lo_d    = '0;
                    hi_d    = '0;
                end else if (req) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end
            end
            StLow: begin
                sram.addr = lo_addr;
                if (is_store) begin
                    sram.wdata = val_rm[15:0];
                    sram.we_n  = 1'b0;
                end else begin
                    sram.oe_n = 1'b0;
                end
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    if (!is_store) lo_d = sram.rdata;
                    state_d = StHigh;
                    cnt_d   = '0;
                end
            end
            StHigh: begin
                sram.addr = hi_addr;
                if (is_store) begin
                    sram.wdata = val_rm[31:16];
                    sram.we_n  = 1'b0;
                end else begin
                    sram.oe_n = 1'b0;
                end
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    if (!is_store) hi_d = sram.rdata;
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign done    = (state_q == StDone);
    assign rd_data = {hi_q, lo_q};

endmodule

// File: rtl/mem_sram_stage.sv
// Memory pipeline stage: SRAM access sequencing, upstream freeze and MEM/WB register.
// Optional MEM_ERR_EN exposes a sticky mem_err output.
module mem_sram_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_OFFSET = DefAddrOffset,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en_in,
    input  logic             mem_r_in,
    input  logic             mem_w_in,
    input  logic [31:0]      alu_res,
    input  logic [31:0]      val_rm,
    input  logic [3:0]       dest_in,
    output logic             freeze,
    output logic             wb_en_out,
    output logic             mem_r_out,
    output logic [31:0]      alu_res_out,
    output logic [31:0]      mem_data_out,
    output logic [3:0]       dest_out,
`ifdef MEM_ERR_EN
    output logic             mem_err,
`endif
    mem_sram_stage_if.master sram
);

    logic        req, done;
    logic [31:0] rd_data;

    assign req    = mem_r_in | mem_w_in;
    assign freeze = req & ~done;

    sram_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_OFFSET (ADDR_OFFSET),
        .SRAM_AW     (SRAM_AW)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .is_store (mem_w_in),
        .alu_res  (alu_res),
        .val_rm   (val_rm),
        .sram     (sram),
`ifdef MEM_ERR_EN
        .mem_err  (mem_err),
`endif
        .done     (done),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out    <= 1'b0;
            mem_r_out    <= 1'b0;
            alu_res_out  <= '0;
            mem_data_out <= '0;
            dest_out     <= '0;
        end else if (!freeze) begin
            wb_en_out    <= wb_en_in;
            mem_r_out    <= mem_r_in & ~mem_w_in;
            alu_res_out  <= alu_res;
            mem_data_out <= rd_data;
            dest_out     <= dest_in;
        end else begin
            // Insert a bubble while the access is in flight.
            wb_en_out <= 1'b0;
            mem_r_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_sram_stage.sv
// Directed self-checking bench for mem_sram_stage with a behavioural async SRAM.
module tb_mem_sram_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en_in = 1'b0, mem_r_in = 1'b0, mem_w_in = 1'b0;
    logic [31:0] alu_res = '0, val_rm = '0;
    logic [3:0]  dest_in = '0;
    logic        freeze, wb_en_out, mem_r_out;
    logic [31:0] alu_res_out, mem_data_out;
    logic [3:0]  dest_out;
`ifdef MEM_ERR_EN
    logic        mem_err;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int excl_viol = 0;

    logic [15:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_a = '0;
    logic [15:0] pre_d = '0;

    mem_sram_stage_if #(.SRAM_AW(18)) sram_bus ();

    mem_sram_stage #(
        .WAIT_CYCLES (2),
        .ADDR_OFFSET (1024),
        .SRAM_AW     (18)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .mem_r_in     (mem_r_in),
        .mem_w_in     (mem_w_in),
        .alu_res      (alu_res),
        .val_rm       (val_rm),
        .dest_in      (dest_in),
        .freeze       (freeze),
        .wb_en_out    (wb_en_out),
        .mem_r_out    (mem_r_out),
        .alu_res_out  (alu_res_out),
        .mem_data_out (mem_data_out),
        .dest_out     (dest_out),
`ifdef MEM_ERR_EN
        .mem_err      (mem_err),
`endif
        .sram         (sram_bus.master)
    );

    always #5 clk = ~clk;

    assign sram_bus.rdata = mem[sram_bus.addr[5:0]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (!sram_bus.we_n) mem[sram_bus.addr[5:0]] <= sram_bus.wdata;
    end

    always @(negedge clk) begin
        if (!sram_bus.we_n && !sram_bus.oe_n) excl_viol <= excl_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic drive(input logic wb, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] dst);
        wb_en_in = wb; mem_r_in = r; mem_w_in = w; alu_res = a; val_rm = d; dest_in = dst;
    endtask

    // Issue one instruction and observe until freeze drops (the capture cycle).
    task automatic run_op(input logic wb, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] dst, input int lo_hw,
                          output int nfrz, output int lo_cyc, output int hi_cyc,
                          output int strb, output int bub, output logic first_frz,
                          output logic [31:0] first_data, output logic first_mr);
        logic done_seen = 1'b0;
        nfrz = 0; lo_cyc = 0; hi_cyc = 0; strb = 0; bub = 0;
        first_frz = 1'b0; first_data = '0; first_mr = 1'b0;
        @(posedge clk); #1;
        drive(wb, r, w, a, d, dst);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                first_frz  = freeze;
                first_data = mem_data_out;
                first_mr   = mem_r_out;
            end
            if (!freeze) begin
                done_seen = 1'b1;
                break;
            end
            nfrz++;
            if (i > 0 && (wb_en_out || mem_r_out)) bub++;
            if (!sram_bus.we_n || !sram_bus.oe_n) strb++;
            if ((w ? !sram_bus.we_n : !sram_bus.oe_n) && int'(sram_bus.addr) == lo_hw) lo_cyc++;
            if ((w ? !sram_bus.we_n : !sram_bus.oe_n) && int'(sram_bus.addr) == lo_hw + 1)
                hi_cyc++;
        end
        check("op_completes", 32'(done_seen), 32'd1);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
    endtask

    int nfrz, lo_cyc, hi_cyc, strb, bub;
    logic first_frz, first_mr;
    logic [31:0] first_data;

    initial begin
        #12;
        check("rst_wb_en", 32'(wb_en_out), 32'd0);
        check("rst_mem_r", 32'(mem_r_out), 32'd0);
        check("rst_alu", alu_res_out, 32'd0);
        check("rst_data", mem_data_out, 32'd0);
        check("rst_dest", 32'(dest_out), 32'd0);
        check("rst_we_n", 32'(sram_bus.we_n), 32'd1);
        check("rst_oe_n", 32'(sram_bus.oe_n), 32'd1);
        check("rst_addr", 32'(sram_bus.addr), 32'd0);
        check("rst_wdata", 32'(sram_bus.wdata), 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
`ifdef MEM_ERR_EN
        check("rst_mem_err", 32'(mem_err), 32'd0);
`endif
        @(negedge clk); rst = 1'b1;

        preload(6'd4, 16'hBEEF);
        preload(6'd5, 16'hDEAD);
        preload(6'd8, 16'h1111);
        preload(6'd9, 16'h2222);

        // ALU pass-through.
        run_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3, 0,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        check("alu_no_freeze", 32'(nfrz), 32'd0);
        go_idle();
        check("alu_wb_en", 32'(wb_en_out), 32'd1);
        check("alu_res_out", alu_res_out, 32'h55);
        check("alu_dest", 32'(dest_out), 32'd3);
        check("alu_mem_r", 32'(mem_r_out), 32'd0);

        // Load at 1032 -> halfwords 4 and 5.
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7, 4,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        check("ld_freeze_len", 32'(nfrz), 32'd7);
        check("ld_lo_cycles", 32'(lo_cyc), 32'd3);
        check("ld_hi_cycles", 32'(hi_cyc), 32'd3);
        check("ld_bubbles", 32'(bub), 32'd0);
        go_idle();
        check("ld_data", mem_data_out, 32'hDEADBEEF);
        check("ld_mem_r", 32'(mem_r_out), 32'd1);
        check("ld_wb_en", 32'(wb_en_out), 32'd1);
        check("ld_dest", 32'(dest_out), 32'd7);
        check("ld_alu", alu_res_out, 32'd1032);

        // Store at 1028 -> halfwords 2 and 3, then read back.
        run_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'h12345678, 4'd0, 2,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        check("st_freeze_len", 32'(nfrz), 32'd7);
        check("st_we_lo", 32'(lo_cyc), 32'd3);
        check("st_we_hi", 32'(hi_cyc), 32'd3);
        go_idle();
        check("st_hw2", 32'(mem[2]), 32'h5678);
        check("st_hw3", 32'(mem[3]), 32'h1234);
        run_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd2, 2,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        go_idle();
        check("st_readback", mem_data_out, 32'h12345678);

        // Read and write both set: treated as a store, load flag cleared.
        run_op(1'b0, 1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 4'd1, 6,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        check("rw_we_lo", 32'(lo_cyc), 32'd3);
        go_idle();
        check("rw_mem_r", 32'(mem_r_out), 32'd0);
        check("rw_hw6", 32'(mem[6]), 32'hF00D);
        check("rw_hw7", 32'(mem[7]), 32'hCAFE);

        // Back-to-back loads: a single unfrozen cycle between windows.
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd4, 4,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        check("b2b_a_len", 32'(nfrz), 32'd7);
        run_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd5, 8,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        check("b2b_gap", 32'(first_frz), 32'd1);
        check("b2b_a_data", first_data, 32'hDEADBEEF);
        check("b2b_a_mem_r", 32'(first_mr), 32'd1);
        check("b2b_b_len", 32'(nfrz), 32'd7);
        go_idle();
        check("b2b_b_data", mem_data_out, 32'h22221111);

        // Reset during the high-half access.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd9);
        repeat (5) @(negedge clk);
        check("mid_in_high", 32'(sram_bus.addr), 32'd5);
        #1 rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("mid_oe_n", 32'(sram_bus.oe_n), 32'd1);
        check("mid_we_n", 32'(sram_bus.we_n), 32'd1);
        check("mid_addr", 32'(sram_bus.addr), 32'd0);
        check("mid_data", mem_data_out, 32'd0);
        check("mid_wb_en", 32'(wb_en_out), 32'd0);
        check("mid_alu", alu_res_out, 32'd0);
        check("mid_freeze", 32'(freeze), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        run_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd6, 8,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        check("post_rst_len", 32'(nfrz), 32'd7);
        go_idle();
        check("post_rst_data", mem_data_out, 32'h22221111);

`ifdef MEM_ERR_EN
        run_op(1'b1, 1'b1, 1'b0, 32'd1026, 32'h0, 4'd8, 0,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        check("err_freeze_len", 32'(nfrz), 32'd1);
        check("err_no_strobe", 32'(strb), 32'd0);
        go_idle();
        check("err_data", mem_data_out, 32'd0);
        check("err_flag", 32'(mem_err), 32'd1);
        run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd8, 4,
               nfrz, lo_cyc, hi_cyc, strb, bub, first_frz, first_data, first_mr);
        go_idle();
        check("err_sticky", 32'(mem_err), 32'd1);
        check("err_then_ok", mem_data_out, 32'hDEADBEEF);
`endif

        check("strobe_exclusive", 32'(excl_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
